cv32e40s_bit_iter: RTL and testbench
====================================

CV32E40S_BIT_ITER -- requirements
Module: cv32e40s_bit_iter

Interface
REQ-001 Parameter LEN, default 32, SHALL set the input vector width; legal range LEN >= 2, non-power-of-2 supported.
REQ-002 Parameter RR, default 0, SHALL select the mode: 0 = lowest-index-first per vector; 1 = round-robin, with the search starting after the last emitted index.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid_i  input  1  request vector present.
REQ-006 in_ready_o  output  1  block accepts a vector.
REQ-007 in_vec_i  input  LEN  bit vector to iterate.
REQ-008 kill_i  input  1  abort the current iteration.
REQ-009 out_valid_o  output  1  out_idx_o is valid.
REQ-010 out_ready_i  input  1  consumer takes the index.
REQ-011 out_idx_o  output  $clog2(LEN)  index of the selected set bit.
REQ-012 out_last_o  output  1  the current index is the final set bit of the vector.
REQ-013 busy_o  output  1  state is ITER.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and ITER, with a registered vector vec_q[LEN-1:0] and a registered pointer ptr_q[$clog2(LEN)-1:0].
REQ-015 in_ready_o SHALL be 1 in IDLE and 0 in ITER.
REQ-016 In IDLE, in_valid_i=1 with in_vec_i!=0 SHALL load vec_q and enter ITER on the next edge.
REQ-017 In IDLE, in_valid_i=1 with in_vec_i==0 SHALL accept the vector, produce no output and remain in IDLE.
REQ-018 out_valid_o SHALL be 1 exactly when the state is ITER; the first index SHALL be valid the cycle after acceptance.
REQ-019 In RR=0, out_idx_o SHALL be the lowest set index of vec_q.
REQ-020 In RR=1, out_idx_o SHALL be the lowest set index >= ptr_q if one exists, otherwise the lowest set index overall (wrap-around).
REQ-021 out_last_o SHALL be 1 when vec_q has exactly one bit set.
REQ-022 On a handshake (out_valid_o & out_ready_i), the bit at out_idx_o SHALL be cleared in vec_q; if out_last_o=1, the FSM SHALL return to IDLE.
REQ-023 Throughput SHALL be one index per cycle under continuous out_ready_i; a new vector SHALL be accepted no earlier than the cycle after the last handshake (one-cycle bubble).
REQ-024 While out_ready_i=0, out_idx_o, out_last_o and vec_q SHALL be held stable.
REQ-025 On each handshake in RR=1, ptr_q SHALL update to out_idx_o+1, wrapping LEN-1 -> 0; ptr_q SHALL persist across vectors and SHALL be unused and held at 0 in RR=0.
REQ-026 kill_i=1 in ITER SHALL clear vec_q and enter IDLE on the next edge.
REQ-027 A handshake in the same cycle as kill_i SHALL count as completed, so ptr_q updates; kill_i SHALL be ignored in IDLE.
REQ-028 Outputs SHALL be combinational only from registered state, except that no path from out_ready_i to out_valid_o is permitted.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force IDLE, vec_q=0 and ptr_q=0, giving out_valid_o=0, out_idx_o=0, out_last_o=0, busy_o=0 and in_ready_o=1.
REQ-030 Reset asserted mid-iteration SHALL discard the remaining bits with no further out_valid_o.
REQ-031 Reset SHALL have priority over kill_i, handshakes and acceptance.

Structure
REQ-032 The state enum (IDLE/ITER) SHALL be placed in cv32e40s_pkg; no other shared constants are required.
REQ-033 The priority search SHALL reuse two instances of sub-module cv32e40s_ff_one: one on vec_q masked to indices >= ptr_q, one on unmasked vec_q; the masked result is selected when it is non-empty.
REQ-034 In RR=0 the masked instance SHALL be omitted by generate.

Verification
REQ-035 RR=0, LEN=8, vector 0xA4, out_ready_i=1 -> idx 2,5,7 on consecutive cycles, out_last_o on 7, in_ready_o=1 on the following cycle.
REQ-036 RR=0, LEN=8, vector 0x30, out_ready_i=0 for 3 cycles -> idx 4 held stable for 3 cycles, then 4,5 emitted.
REQ-037 Zero vector accepted in IDLE -> out_valid_o stays 0 and in_ready_o stays 1.
REQ-038 RR=1, LEN=8, sequence 0x81, 0x06, 0x09 -> idx 0,7 | 1,2 | 3,0; ptr_q ends at 1.
REQ-039 RR=1, LEN=5, vector 0x11 -> idx 0,4; ptr_q wraps to 0.
REQ-040 Vector 0xFF with kill_i pulsed after 2 handshakes -> out_valid_o=0 next cycle, in_ready_o=1.
REQ-041 Same stimulus with rst_n pulsed instead of kill_i -> out_valid_o=0 next cycle, in_ready_o=1, ptr_q=0.

Source files
------------

// File: rtl/cv32e40s_pkg.sv
// Shared types for the bit iterator.
package cv32e40s_pkg;

    // Bit iterator control state
    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } bit_iter_state_e;

endpackage

// File: rtl/cv32e40s_ff_one.sv
// Find-first-one: index of the lowest set bit of in_i, plus an empty flag.
module cv32e40s_ff_one
    import cv32e40s_pkg::*;
#(
    parameter int unsigned LEN = 32
) (
    input  logic [LEN-1:0]         in_i,
    output logic [$clog2(LEN)-1:0] first_one_o,
    output logic                   no_ones_o
);

    localparam int unsigned IW = $clog2(LEN);

    // Scan from the top down so the lowest set index wins
    always_comb begin
        first_one_o = '0;
        for (int i = LEN - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                first_one_o = IW'(i);
            end
        end
    end

    assign no_ones_o = ~|in_i;

endmodule

// File: rtl/cv32e40s_bit_iter.sv
// Emits the indices of the set bits of an accepted vector, one per handshake.
// RR=0 walks lowest-first; RR=1 resumes the search after the last emitted index.
module cv32e40s_bit_iter
    import cv32e40s_pkg::*;
#(
    parameter int unsigned LEN = 32,
    parameter int unsigned RR  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [LEN-1:0]         in_vec_i,
    input  logic                   kill_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [$clog2(LEN)-1:0] out_idx_o,
    output logic                   out_last_o,
    output logic                   busy_o
);

    localparam int unsigned IW = $clog2(LEN);

    bit_iter_state_e state_q;
    logic [LEN-1:0]  vec_q;
    logic [IW-1:0]   ptr_q;

    logic [IW-1:0]   full_idx;
    logic            full_empty;
    logic [IW-1:0]   masked_idx;
    logic            masked_hit;
    logic [IW-1:0]   sel_idx;
    logic [LEN-1:0]  idx_onehot;
    logic [IW-1:0]   next_ptr;

    // Lowest set bit over the whole vector
    cv32e40s_ff_one #(
        .LEN (LEN)
    ) u_ff_full (
        .in_i        (vec_q),
        .first_one_o (full_idx),
        .no_ones_o   (full_empty)
    );

    generate
        if (RR != 0) begin : g_rr
            logic [LEN-1:0] ge_mask;
            logic [LEN-1:0] masked_vec;
            logic           masked_empty;

            // Keep only indices at or above the round-robin pointer
            always_comb begin
                ge_mask = '0;
                for (int i = 0; i < LEN; i++) begin
                    ge_mask[i] = ($unsigned(i) >= 32'(ptr_q));
                end
            end

            assign masked_vec = vec_q & ge_mask;

            cv32e40s_ff_one #(
                .LEN (LEN)
            ) u_ff_masked (
                .in_i        (masked_vec),
                .first_one_o (masked_idx),
                .no_ones_o   (masked_empty)
            );

            assign masked_hit = ~masked_empty;
        end else begin : g_lof
            // Pointer is held at zero and plays no part in the search here
            logic ptr_unused;
            assign ptr_unused = ^ptr_q;
            assign masked_idx = '0;
            assign masked_hit = 1'b0;
        end
    endgenerate

    // Prefer the hit above the pointer, else wrap to the overall lowest
    assign sel_idx    = masked_hit ? masked_idx : full_idx;
    assign idx_onehot = LEN'(1) << sel_idx;
    assign next_ptr   = (sel_idx == IW'(LEN - 1)) ? '0 : sel_idx + IW'(1);

    // Control state, remaining bits and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            ptr_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // An all-zero vector is consumed without leaving IDLE
                    if (in_valid_i && (in_vec_i != '0)) begin
                        vec_q   <= in_vec_i;
                        state_q <= ITER;
                    end
                end
                ITER: begin
                    // A handshake coincident with kill still advances the pointer
                    if (out_ready_i && (RR != 0)) begin
                        ptr_q <= next_ptr;
                    end
                    if (kill_i) begin
                        vec_q   <= '0;
                        state_q <= IDLE;
                    end else if (out_ready_i) begin
                        vec_q <= vec_q & ~idx_onehot;
                        if (out_last_o) begin
                            state_q <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == ITER);
    assign busy_o      = (state_q == ITER);
    assign out_idx_o   = sel_idx;
    assign out_last_o  = ~full_empty & ~|(vec_q & (vec_q - LEN'(1)));

endmodule

// File: tb/tb_cv32e40s_bit_iter.sv
// Bench for cv32e40s_bit_iter: three instances (LEN8/RR0, LEN8/RR1, LEN5/RR1)
// checked against a set-of-bits reference model, directed tables and random traffic.
module tb_cv32e40s_bit_iter;

    logic            clk;
    logic            rst_n;
    logic [2:0]      in_valid;
    logic [2:0]      kill;
    logic [2:0]      out_ready;
    logic [2:0][7:0] in_vec;
    logic [2:0]      ovalid;
    logic [2:0]      iready;
    logic [2:0]      olast;
    logic [2:0]      busy;
    logic [2:0][2:0] idx;

    int pass_cnt;
    int total_cnt;

    // Reference model: the set of not-yet-emitted bits and the search pointer
    logic [7:0] m_vec [3];
    int         m_ptr [3];
    int         m_len [3];
    int         m_rr  [3];

    typedef struct {
        int         d;
        logic [7:0] v;
        int         n;
        int         seq [8];
    } vec_t;

    vec_t tbl [6];

    cv32e40s_bit_iter #(.LEN(8), .RR(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid[0]), .in_ready_o(iready[0]),
        .in_vec_i(in_vec[0]), .kill_i(kill[0]), .out_valid_o(ovalid[0]),
        .out_ready_i(out_ready[0]), .out_idx_o(idx[0]), .out_last_o(olast[0]), .busy_o(busy[0])
    );

    cv32e40s_bit_iter #(.LEN(8), .RR(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid[1]), .in_ready_o(iready[1]),
        .in_vec_i(in_vec[1]), .kill_i(kill[1]), .out_valid_o(ovalid[1]),
        .out_ready_i(out_ready[1]), .out_idx_o(idx[1]), .out_last_o(olast[1]), .busy_o(busy[1])
    );

    cv32e40s_bit_iter #(.LEN(5), .RR(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid[2]), .in_ready_o(iready[2]),
        .in_vec_i(in_vec[2][4:0]), .kill_i(kill[2]), .out_valid_o(ovalid[2]),
        .out_ready_i(out_ready[2]), .out_idx_o(idx[2]), .out_last_o(olast[2]), .busy_o(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Index the specification's search rule picks for instance j
    function automatic int ref_idx(input int j);
        if (m_rr[j] != 0) begin
            for (int i = m_ptr[j]; i < m_len[j]; i++) if (m_vec[j][i]) return i;
        end
        for (int i = 0; i < m_len[j]; i++) if (m_vec[j][i]) return i;
        return 0;
    endfunction

    task automatic check_all();
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("d%0d_valid", j), 32'(ovalid[j]), 32'(m_vec[j] != 0));
            chk($sformatf("d%0d_in_ready", j), 32'(iready[j]), 32'(m_vec[j] == 0));
            chk($sformatf("d%0d_busy", j), 32'(busy[j]), 32'(m_vec[j] != 0));
            chk($sformatf("d%0d_idx", j), 32'(idx[j]), 32'(ref_idx(j)));
            chk($sformatf("d%0d_last", j), 32'(olast[j]), 32'($countones(m_vec[j]) == 1));
        end
    endtask

    // Advance the model across one rising edge using the inputs just applied
    task automatic model_step(input int j);
        int i;
        if (!rst_n) begin
            m_vec[j] = '0;
            m_ptr[j] = 0;
        end else if (m_vec[j] == 0) begin
            if (in_valid[j]) m_vec[j] = in_vec[j] & 8'((1 << m_len[j]) - 1);
        end else begin
            i = ref_idx(j);
            if (out_ready[j] && (m_rr[j] != 0)) m_ptr[j] = (i + 1) % m_len[j];
            if (kill[j]) m_vec[j] = '0;
            else if (out_ready[j]) m_vec[j][i] = 1'b0;
        end
    endtask

    // One clock: check at the falling edge, drive, clock, update model
    task automatic cyc(input int d, input bit v, input logic [7:0] vv,
                       input bit k, input bit r, input bit rs);
        check_all();
        in_valid  = '0;
        kill      = '0;
        out_ready = '0;
        in_vec    = '0;
        in_valid[d]  = v;
        in_vec[d]    = vv;
        kill[d]      = k;
        out_ready[d] = r;
        rst_n        = rs;
        @(posedge clk);
        for (int j = 0; j < 3; j++) model_step(j);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t t);
        cyc(t.d, 1'b1, t.v, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < t.n; k++) begin
            chk($sformatf("tbl_d%0d_v%02h_idx%0d", t.d, t.v, k), 32'(idx[t.d]), 32'(t.seq[k]));
            chk($sformatf("tbl_d%0d_v%02h_last%0d", t.d, t.v, k), 32'(olast[t.d]), 32'(k == t.n - 1));
            chk($sformatf("tbl_d%0d_v%02h_valid%0d", t.d, t.v, k), 32'(ovalid[t.d]), 32'd1);
            cyc(t.d, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        end
        chk($sformatf("tbl_d%0d_v%02h_ready_after", t.d, t.v), 32'(iready[t.d]), 32'd1);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        m_len = '{8, 8, 5};
        m_rr  = '{0, 1, 1};
        for (int j = 0; j < 3; j++) begin
            m_vec[j] = '0;
            m_ptr[j] = 0;
        end
        rst_n = 1'b0; in_valid = '0; kill = '0; out_ready = '0; in_vec = '0;

        tbl[0] = '{0, 8'hA4, 3, '{2, 5, 7, 0, 0, 0, 0, 0}};
        tbl[1] = '{0, 8'h0F, 4, '{0, 1, 2, 3, 0, 0, 0, 0}};
        tbl[2] = '{1, 8'h81, 2, '{0, 7, 0, 0, 0, 0, 0, 0}};
        tbl[3] = '{1, 8'h06, 2, '{1, 2, 0, 0, 0, 0, 0, 0}};
        tbl[4] = '{1, 8'h09, 2, '{3, 0, 0, 0, 0, 0, 0, 0}};
        tbl[5] = '{2, 8'h11, 2, '{0, 4, 0, 0, 0, 0, 0, 0}};

        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_valid", 32'(ovalid[0]), 32'd0);
        chk("rst_in_ready", 32'(iready[1]), 32'd1);
        chk("rst_idx", 32'(idx[1]), 32'd0);
        chk("rst_ptr", 32'(dut_b.ptr_q), 32'd0);
        cyc(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Directed vectors with continuous ready
        for (int t = 0; t < 6; t++) run_vec(tbl[t]);
        chk("rr_ptr_after_seq", 32'(dut_b.ptr_q), 32'd1);
        chk("rr5_ptr_wrap", 32'(dut_c.ptr_q), 32'd0);
        chk("lof_ptr_zero", 32'(dut_a.ptr_q), 32'd0);

        // Backpressure holds index 4 for three cycles
        cyc(0, 1'b1, 8'h30, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold_idx%0d", k), 32'(idx[0]), 32'd4);
            chk($sformatf("hold_last%0d", k), 32'(olast[0]), 32'd0);
            cyc(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        chk("hold_rel_idx4", 32'(idx[0]), 32'd4);
        cyc(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("hold_rel_idx5", 32'(idx[0]), 32'd5);
        chk("hold_rel_last", 32'(olast[0]), 32'd1);
        cyc(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Zero vector is swallowed in IDLE
        cyc(0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("zero_valid", 32'(ovalid[0]), 32'd0);
        chk("zero_in_ready", 32'(iready[0]), 32'd1);

        // Kill after two handshakes
        cyc(0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
        cyc(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        cyc(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        cyc(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("kill_valid", 32'(ovalid[0]), 32'd0);
        chk("kill_in_ready", 32'(iready[0]), 32'd1);

        // Kill with a coincident handshake still moves the pointer (ptr 1 -> 2 -> 3)
        cyc(1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
        cyc(1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        cyc(1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("killhs_valid", 32'(ovalid[1]), 32'd0);
        chk("killhs_ptr", 32'(dut_b.ptr_q), 32'd3);
        cyc(1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("kill_idle_ignored", 32'(iready[1]), 32'd1);

        // Reset mid-iteration
        cyc(1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
        cyc(1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        cyc(1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        cyc(1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
        chk("rstmid_valid", 32'(ovalid[1]), 32'd0);
        chk("rstmid_in_ready", 32'(iready[1]), 32'd1);
        chk("rstmid_ptr", 32'(dut_b.ptr_q), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            int          d;
            logic [7:0]  vv;
            d  = int'($urandom_range(0, 2));
            vv = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            cyc(d, 1'($urandom), vv, ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) != 0));
        end
        check_all();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
